// File: rtl/lfsr_pkg.sv
// Shared LFSR constants: maximal-length feedback masks and the default seed.
package lfsr_pkg;

  localparam logic [7:0]  LFSR_W8_TAPS      = 8'hB8;
  localparam logic [15:0] LFSR_W16_TAPS     = 16'hB400;
  localparam logic [31:0] LFSR_W32_TAPS     = 32'h80200003;
  localparam logic [31:0] LFSR_DEFAULT_SEED = 32'd1;

endpackage

// File: rtl/lfsr_stream_if.sv
// Ready/valid output stream carrying one LFSR word per transfer.
interface lfsr_stream_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/lfsr_step.sv
// Combinational Fibonacci LFSR advance: applies STEP single shifts of state using the TAPS mask.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_W8_TAPS),
  parameter int               STEP  = 1
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] state_next
);

  // Unrolled chain of single shifts; new bit enters at the LSB.
  always_comb begin
    state_next = state;
    for (int i = 0; i < STEP; i++) begin
      state_next = {state_next[WIDTH-2:0], ^(state_next & TAPS)};
    end
  end

endmodule

// File: rtl/lfsr_stream.sv
// Parametrised LFSR word generator with ready/valid output, runtime seed load and multi-shift advance.
// Optional period counter ports are enabled by defining LFSR_STREAM_PERIOD_EN.
module lfsr_stream
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_W8_TAPS),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR_DEFAULT_SEED),
  parameter int               STEP  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              seed_load,
  input  logic [WIDTH-1:0]  seed,
  lfsr_stream_if.master     stream,
  output logic              zero_seed_err
`ifdef LFSR_STREAM_PERIOD_EN
  ,
  output logic [WIDTH-1:0]  period_cnt,
  output logic              period_done,
  output logic [WIDTH-1:0]  period_last
`endif
);

  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_stream: WIDTH must be within 3..32");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_stream: SEED must be nonzero");
  end
  if (TAPS == '0) begin : g_bad_taps
    $error("lfsr_stream: TAPS must be nonzero");
  end
  if (STEP < 1 || STEP > WIDTH) begin : g_bad_step
    $error("lfsr_stream: STEP must be within 1..WIDTH");
  end

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] state_next;
  logic [WIDTH-1:0] load_value;
  logic             adv;

  lfsr_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .STEP  (STEP)
  ) u_step (
    .state      (state),
    .state_next (state_next)
  );

  // A zero seed would lock the register, so the reset seed stands in for it.
  assign load_value = (seed == '0) ? SEED : seed;
  assign adv        = en & ~seed_load & (~stream.out_valid | stream.out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= SEED;
      stream.out_data  <= '0;
      stream.out_valid <= 1'b0;
      zero_seed_err    <= 1'b0;
    end else if (seed_load) begin
      state            <= load_value;
      stream.out_valid <= 1'b0;
      if (seed == '0) begin
        zero_seed_err <= 1'b1;
      end
    end else if (adv) begin
      stream.out_data  <= state;
      stream.out_valid <= 1'b1;
      state            <= state_next;
    end else if (stream.out_valid && stream.out_ready) begin
      stream.out_valid <= 1'b0;
    end
  end

`ifdef LFSR_STREAM_PERIOD_EN
  logic [WIDTH-1:0] ref_seed;

  // The period closes on the advance that brings the state back to the last loaded seed.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_seed    <= SEED;
      period_cnt  <= '0;
      period_done <= 1'b0;
      period_last <= '0;
    end else begin
      period_done <= 1'b0;
      if (seed_load) begin
        ref_seed   <= load_value;
        period_cnt <= '0;
      end else if (adv) begin
        if (state_next == ref_seed) begin
          period_done <= 1'b1;
          period_last <= period_cnt + WIDTH'(1);
          period_cnt  <= '0;
        end else begin
          period_cnt <= period_cnt + WIDTH'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_stream.sv
// Self-checking bench for lfsr_stream: directed steps plus random traffic against a sequence-position model.
// Exercises the LFSR_STREAM_PERIOD_EN ports when that macro is defined.
module tb_lfsr_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       seed_load;
  logic [7:0] seed;
  logic       en8;
  logic       err;
  logic       err8;

  lfsr_stream_if #(.WIDTH(8)) bus ();
  lfsr_stream_if #(.WIDTH(8)) bus8 ();

`ifdef LFSR_STREAM_PERIOD_EN
  logic [7:0] pcnt;
  logic       pdone;
  logic [7:0] plast;
  logic [7:0] pcnt8;
  logic       pdone8;
  logic [7:0] plast8;
`endif

  lfsr_stream dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .seed_load     (seed_load),
    .seed          (seed),
    .stream        (bus),
    .zero_seed_err (err)
`ifdef LFSR_STREAM_PERIOD_EN
    ,
    .period_cnt    (pcnt),
    .period_done   (pdone),
    .period_last   (plast)
`endif
  );

  lfsr_stream #(.STEP(8)) dut8 (
    .clk           (clk),
    .rst           (rst),
    .en            (en8),
    .seed_load     (1'b0),
    .seed          (8'h00),
    .stream        (bus8),
    .zero_seed_err (err8)
`ifdef LFSR_STREAM_PERIOD_EN
    ,
    .period_cnt    (pcnt8),
    .period_done   (pdone8),
    .period_last   (plast8)
`endif
  );

  always #5 clk = ~clk;

  // Reference: the whole maximal sequence from 01, addressed by position.
  logic [7:0] seq [255];
  int         idx_of [256];
  int         m_pos;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_err;
  int         n_vec = 0;
  int         n_err = 0;

  function automatic logic [7:0] shift1(input logic [7:0] s);
    int v;
    int p;
    v = int'(s);
    p = $countones(s & 8'hB8) % 2;
    return 8'((v * 2) % 256 + p);
  endfunction

  task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    expectEq("valid", 32'(bus.out_valid), 32'(m_valid));
    expectEq("data", 32'(bus.out_data), 32'(m_data));
    expectEq("zero_seed_err", 32'(err), 32'(m_err));
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic l,
                               input logic [7:0] s, input logic rdy);
    rst           = r;
    en            = e;
    seed_load     = l;
    seed          = s;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
    if (r) begin
      m_pos   = 0;
      m_data  = 8'h00;
      m_valid = 1'b0;
      m_err   = 1'b0;
    end else if (l) begin
      m_pos   = idx_of[(s == 8'h00) ? 1 : int'(s)];
      m_valid = 1'b0;
      if (s == 8'h00) m_err = 1'b1;
    end else if (e && (!m_valid || rdy)) begin
      m_data  = seq[m_pos];
      m_valid = 1'b1;
      m_pos   = (m_pos + 1) % 255;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    checkOutput();
  endtask

  initial begin
    logic [7:0] exp_lit [6];
    logic       seen [256];
    logic       r, e, l, rdy;
    logic [7:0] s;
    int         pulses;
    logic [7:0] last_cap;

    exp_lit = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
    en8 = 1'b0;
    bus8.out_ready = 1'b1;
    seq[0] = 8'h01;
    for (int i = 1; i < 255; i++) seq[i] = shift1(seq[i-1]);
    for (int i = 0; i < 256; i++) idx_of[i] = -1;
    for (int i = 0; i < 255; i++) idx_of[seq[i]] = i;

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    $display("[TB] default sequence");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
      expectEq("lit_seq", 32'(bus.out_data), 32'(exp_lit[i]));
    end

    $display("[TB] backpressure");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      expectEq("stall_data", 32'(bus.out_data), 32'h23);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    expectEq("after_stall", 32'(bus.out_data), 32'h47);

    $display("[TB] seed load");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h5A, 1'b1);
    expectEq("load_valid", 32'(bus.out_valid), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    expectEq("load_word", 32'(bus.out_data), 32'h5A);
    expectEq("load_err", 32'(err), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h00, 1'b1);
    expectEq("zero_err", 32'(err), 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    expectEq("zero_word", 32'(bus.out_data), 32'h01);

    $display("[TB] enable toggling");
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 99) == 0);
      e   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      l   = ($urandom_range(0, 24) == 0);
      s   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      applyStimulus(r, e, l, s, rdy);
    end

    $display("[TB] reset clears flag");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    expectEq("rst_err", 32'(err), 32'h0);

    $display("[TB] STEP=8 period and full-rate stream");
    en8      = 1'b1;
    pulses   = 0;
    last_cap = 8'h00;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int k = 0; k < 256; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
      expectEq("s8_valid", 32'(bus8.out_valid), 32'h1);
      expectEq("s8_data", 32'(bus8.out_data), 32'(seq[(8 * k) % 255]));
      if (k < 255) begin
        expectEq("s8_nonzero", 32'(bus8.out_data == 8'h00), 32'h0);
        expectEq("s8_unique", 32'(seen[bus8.out_data]), 32'h0);
        seen[bus8.out_data] = 1'b1;
      end
`ifdef LFSR_STREAM_PERIOD_EN
      if (pdone) begin
        pulses++;
        last_cap = plast;
      end
`endif
    end
`ifdef LFSR_STREAM_PERIOD_EN
    expectEq("period_pulses", 32'(pulses), 32'd1);
    expectEq("period_last", 32'(last_cap), 32'd255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
